rc4_decrypt_ctrl: RTL

- Downstream consumer of the RC4 keystream/PRGA control FSM.
- After the S-array is generated, it requests keystream bytes one at a time over the genVal/valReady handshake.
- It XORs each keystream byte with a ciphertext byte read from a synchronous ROM/RAM and writes the plaintext to an output RAM.
- It judges the candidate key by checking every plaintext byte against a printable-character range, and reports done plus key verdict to the key-search controller.

---
 rtl/rc4_decrypt_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/rc4_decrypt_ctrl.sv
// RC4 decrypt controller: pulls keystream bytes, XORs with ciphertext ROM, writes plaintext, judges the key.
// Optional macro RC4_DECRYPT_EARLY_ABORT_EN: stop at the first out-of-range byte without writing it.
module rc4_decrypt_ctrl #(
    parameter int unsigned MSG_LEN = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter logic [7:0]  CHAR_LO = 8'h20,
    parameter logic [7:0]  CHAR_HI = 8'h7E
) (
    input  logic              clk,
    input  logic              n_rst_i,
    input  logic              start_i,
    output logic              gen_val_o,
    input  logic              val_ready_i,
    input  logic [7:0]        keystream_i,
    output logic [ADDR_W-1:0] ct_addr_o,
    input  logic [7:0]        ct_data_i,
    output logic              pt_we_o,
    output logic [ADDR_W-1:0] pt_addr_o,
    output logic [7:0]        pt_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              key_ok_o
);
    localparam int unsigned       BYTE_W   = 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);

`ifdef RC4_DECRYPT_EARLY_ABORT_EN
    localparam bit EARLY_ABORT = 1'b1;
`else
    localparam bit EARLY_ABORT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ARM,
        S_WAIT_KS,
        S_WRITE,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   pa_q, pa_d;
    logic [BYTE_W-1:0]   pt_q, pt_d;
    logic                bad_q, bad_d;
    logic                inr_q, inr_d;
    logic                key_ok_q, key_ok_d;
    logic                gen_val_q, gen_val_d;
    logic                pt_we_q, pt_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [BYTE_W-1:0]   pt_c;
    logic                pt_in_range_c;
    logic                last_c;
    logic                abort_c;

    assign pt_c          = keystream_i ^ ct_data_i;
    assign pt_in_range_c = (pt_c >= CHAR_LO) && (pt_c <= CHAR_HI);
    assign last_c        = (idx_q == LAST_IDX);
    assign abort_c       = EARLY_ABORT && !inr_q;

    // State register
    always_ff @(posedge clk or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ARM exists to skip the stale valReady left over from the previous byte
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_REQ;
            S_REQ:     state_d = S_ARM;
            S_ARM:     state_d = S_WAIT_KS;
            S_WAIT_KS: if (val_ready_i) state_d = S_WRITE;
            S_WRITE:   state_d = (abort_c || last_c) ? S_DONE : S_REQ;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values, outputs decoded from the upcoming state so they register cleanly
    always_comb begin
        idx_d    = idx_q;
        pa_d     = pa_q;
        pt_d     = pt_q;
        bad_d    = bad_q;
        inr_d    = inr_q;
        key_ok_d = key_ok_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    idx_d    = '0;
                    bad_d    = 1'b0;
                    key_ok_d = 1'b0;
                end
            end
            S_WAIT_KS: begin
                if (val_ready_i) begin
                    pt_d  = pt_c;
                    pa_d  = idx_q;
                    inr_d = pt_in_range_c;
                end
            end
            S_WRITE: begin
                if (!inr_q) begin
                    bad_d = 1'b1;
                end
                // Terminal compare happens before the increment, so idx never wraps
                if (state_d == S_DONE) begin
                    key_ok_d = !bad_q && inr_q;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
        gen_val_d = (state_d == S_REQ);
        pt_we_d   = (state_d == S_WRITE) && (inr_d || !EARLY_ABORT);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge n_rst_i) begin
        if (!n_rst_i) begin
            idx_q     <= '0;
            pa_q      <= '0;
            pt_q      <= '0;
            bad_q     <= 1'b0;
            inr_q     <= 1'b0;
            key_ok_q  <= 1'b0;
            gen_val_q <= 1'b0;
            pt_we_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            pa_q      <= pa_d;
            pt_q      <= pt_d;
            bad_q     <= bad_d;
            inr_q     <= inr_d;
            key_ok_q  <= key_ok_d;
            gen_val_q <= gen_val_d;
            pt_we_q   <= pt_we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign gen_val_o = gen_val_q;
    assign ct_addr_o = idx_q;
    assign pt_we_o   = pt_we_q;
    assign pt_addr_o = pa_q;
    assign pt_data_o = pt_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign key_ok_o  = key_ok_q;

endmodule
